tmec_decode_control: RTL and testbench

Sequencer for the parallel inversionless Berlekamp (tMEC) error-locator engine. It issues the synpe / snce / msmpe / bsel strobe sequence for one codeword. It tracks the locator length L from the engine's `drnzero` feedback and hands the finished locator to the Chien search with a `ch_start` handshake. It sits between the syndrome unit (which raises `start`) and the Chien search (which raises `ch_ready`).

---
 rtl/tmec_pkg.sv | 19 +
 rtl/tmec_len_tracker.sv | 57 +++++
 rtl/tmec_decode_control.sv | 93 +++++++++
 tb/tb_tmec_decode_control.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmec_pkg.sv
// Shared types and helpers for the tMEC error-locator sequencer.
package tmec_pkg;

  localparam int unsigned TCQ = 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StMsm,
    StUpd,
    StFin
  } tmec_state_e;

  // len never exceeds 2T-1, so this width holds it without wrapping.
  function automatic int unsigned tmec_len_width(input int unsigned t);
    return $clog2(2 * t);
  endfunction

endpackage

// File: rtl/tmec_len_tracker.sv
// Locator length L and iteration counter k for the inversionless Berlekamp loop.
module tmec_len_tracker
  import tmec_pkg::*;
#(
  parameter int unsigned T = 3,
  localparam int unsigned LW = tmec_len_width(T)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          load_i,
  input  logic          update_i,
  input  logic          drnzero_i,
  output logic          bsel_o,
  output logic          last_o,
  output logic [LW-1:0] len_o
);

  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] k_q, k_d;
  logic [LW:0]   two_k_plus_one;
  logic [LW-1:0] len_swap;

  // {k,1} is 2k+1; the subtraction stays positive because it is only used when len <= k.
  assign two_k_plus_one = {k_q, 1'b1};
  assign len_swap       = LW'(two_k_plus_one - {1'b0, len_q});

  assign bsel_o = update_i && drnzero_i && (len_q <= k_q);
  assign last_o = (k_q == LW'(T - 1));
  assign len_o  = len_q;

  always_comb begin
    len_d = len_q;
    k_d   = k_q;
    if (load_i) begin
      len_d = drnzero_i ? LW'(1) : '0;
      k_d   = LW'(1);
    end else if (update_i) begin
      if (bsel_o) begin
        len_d = len_swap;
      end
      if (!last_o) begin
        k_d = k_q + LW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      len_q <= '0;
      k_q   <= LW'(1);
    end else begin
      len_q <= len_d;
      k_q   <= k_d;
    end
  end

endmodule

// File: rtl/tmec_decode_control.sv
// Strobe sequencer for the parallel tMEC engine: LOAD, T-1 MSM/UPD pairs, then Chien handoff.
module tmec_decode_control
  import tmec_pkg::*;
#(
  parameter int unsigned T = 3,
  localparam int unsigned LW = tmec_len_width(T)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          drnzero,
  input  logic          ch_ready,
  output logic          ready,
  output logic          synpe,
  output logic          snce,
  output logic          msmpe,
  output logic          bsel,
  output logic          ch_start,
  output logic          done,
  output logic [LW-1:0] err_len
);

  tmec_state_e state_q, state_d;
  logic        load;
  logic        update;
  logic        last;

  tmec_len_tracker #(
    .T (T)
  ) u_len_tracker (
    .clk_i     (clk),
    .reset_i   (reset),
    .load_i    (load),
    .update_i  (update),
    .drnzero_i (drnzero),
    .bsel_o    (bsel),
    .last_o    (last),
    .len_o     (err_len)
  );

  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    synpe    = 1'b0;
    snce     = 1'b0;
    msmpe    = 1'b0;
    ch_start = 1'b0;
    done     = 1'b0;
    load     = 1'b0;
    update   = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (start) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        synpe   = 1'b1;
        snce    = 1'b1;
        load    = 1'b1;
        state_d = StMsm;
      end
      StMsm: begin
        msmpe   = 1'b1;
        state_d = StUpd;
      end
      StUpd: begin
        snce    = 1'b1;
        update  = 1'b1;
        state_d = last ? StFin : StMsm;
      end
      StFin: begin
        // Hold the locator until the Chien search can take it.
        if (ch_ready) begin
          ch_start = 1'b1;
          done     = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_tmec_decode_control.sv
// Self-checking bench for tmec_decode_control (T=3 main instance, T=2 side instance).
module tb_tmec_decode_control;

  localparam int unsigned T   = 3;
  localparam int unsigned LW  = 3;
  localparam int unsigned LW2 = 2;

  logic          clk      = 1'b0;
  logic          reset    = 1'b1;
  logic          start    = 1'b0;
  logic          drnzero  = 1'b0;
  logic          ch_ready = 1'b1;
  logic          ready, synpe, snce, msmpe, bsel, ch_start, done;
  logic [LW-1:0] err_len;

  logic           start2    = 1'b0;
  logic           drnzero2  = 1'b1;
  logic           ch_ready2 = 1'b1;
  logic           ready2, synpe2, snce2, msmpe2, bsel2, ch_start2, done2;
  logic [LW2-1:0] err_len2;

  int checks = 0;
  int errors = 0;
  logic [LW-1:0] exp_q[$];
  logic [LW-1:0] last_len = '0;

  always #5 clk = ~clk;

  tmec_decode_control #(
    .T (T)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .drnzero  (drnzero),
    .ch_ready (ch_ready),
    .ready    (ready),
    .synpe    (synpe),
    .snce     (snce),
    .msmpe    (msmpe),
    .bsel     (bsel),
    .ch_start (ch_start),
    .done     (done),
    .err_len  (err_len)
  );

  tmec_decode_control #(
    .T (2)
  ) dut2 (
    .clk      (clk),
    .reset    (reset),
    .start    (start2),
    .drnzero  (drnzero2),
    .ch_ready (ch_ready2),
    .ready    (ready2),
    .synpe    (synpe2),
    .snce     (snce2),
    .msmpe    (msmpe2),
    .bsel     (bsel2),
    .ch_start (ch_start2),
    .done     (done2),
    .err_len  (err_len2)
  );

  // dz[0]: drnzero in LOAD; dz[k]: drnzero in the UPD for iteration k.
  // exp_bsel[k]: bsel expected in that UPD. stall: FIN cycles with ch_ready low.
  task automatic run_word(input string name, input logic [2:0] dz, input logic [2:0] exp_bsel,
                          input logic [LW-1:0] exp_len, input int stall);
    int ncyc;
    logic [6:0] obs, exp_s;
    logic [LW-1:0] e;
    ncyc = 2 * T + stall;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_start got %b want 1", name, ready);
    end
    checks++;
    if (err_len !== last_len) begin
      errors++;
      $display("FAIL %s err_len_hold got %0d want %0d", name, err_len, last_len);
    end
    start = 1'b1;
    exp_q.push_back(exp_len);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (c == 1) drnzero = dz[0];
      else if ((c % 2 == 1) && (c <= 2 * T - 1)) drnzero = dz[(c - 1) / 2];
      else drnzero = 1'($urandom_range(0, 1));
      ch_ready = (c < 2 * T) ? 1'($urandom_range(0, 1)) : (c == ncyc);
      start    = (c >= 2 * T) && (c < ncyc);
      @(negedge clk);
      exp_s[6] = 1'b0;
      exp_s[5] = (c == 1);
      exp_s[4] = (c == 1) || ((c % 2 == 1) && (c >= 3) && (c <= 2 * T - 1));
      exp_s[3] = (c % 2 == 0) && (c <= 2 * T - 2);
      exp_s[2] = 1'b0;
      if ((c % 2 == 1) && (c >= 3) && (c <= 2 * T - 1)) exp_s[2] = exp_bsel[(c - 1) / 2];
      exp_s[1] = (c == ncyc);
      exp_s[0] = (c == ncyc);
      obs = {ready, synpe, snce, msmpe, bsel, ch_start, done};
      checks++;
      if (obs !== exp_s) begin
        errors++;
        $display("FAIL %s strobes cycle %0d got %b want %b (rdy,syn,snce,msm,bsel,chs,done)",
                 name, c, obs, exp_s);
      end
      if (done === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s unexpected_done cycle %0d got done=1 want no done", name, c);
        end else begin
          e = exp_q.pop_front();
          last_len = e;
          if (err_len !== e) begin
            errors++;
            $display("FAIL %s err_len got %0d want %0d", name, err_len, e);
          end
        end
      end
      @(posedge clk);
      #1;
    end
    start    = 1'b0;
    ch_ready = 1'b1;
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    obs = {ready, synpe, snce, msmpe, bsel, ch_start, done};
    checks++;
    if (obs !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_outputs got %b want 1000000", obs);
    end
    checks++;
    if (err_len !== 3'd0) begin
      errors++;
      $display("FAIL reset_err_len got %0d want 0", err_len);
    end
    checks++;
    if ({ready2, done2, err_len2} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_t2 got %b want 1000", {ready2, done2, err_len2});
    end
    @(posedge clk);
    #1;
    reset    = 1'b0;
    last_len = '0;
  endtask

  task automatic test_no_errors();
    run_word("no_errors", 3'b000, 3'b000, 3'd0, 0);
  endtask

  task automatic test_single_error();
    run_word("single_error", 3'b001, 3'b000, 3'd1, 0);
  endtask

  task automatic test_two_errors();
    run_word("two_errors", 3'b011, 3'b010, 3'd2, 0);
  endtask

  task automatic test_overflow();
    run_word("overflow", 3'b111, 3'b110, 3'd3, 0);
  endtask

  task automatic test_overflow_t2();
    logic found;
    logic [LW-1:0] e;
    found = 1'b0;
    @(negedge clk);
    checks++;
    if (ready2 !== 1'b1) begin
      errors++;
      $display("FAIL t2_ready got %b want 1", ready2);
    end
    start2 = 1'b1;
    exp_q.push_back(3'd2);
    @(posedge clk);
    #1;
    start2 = 1'b0;
    for (int c = 1; c <= 12 && !found; c++) begin
      @(negedge clk);
      if (c == 3) begin
        checks++;
        if (bsel2 !== 1'b1) begin
          errors++;
          $display("FAIL t2_bsel got %b want 1", bsel2);
        end
      end
      if (done2 === 1'b1) begin
        found = 1'b1;
        checks++;
        if (c != 4) begin
          errors++;
          $display("FAIL t2_done_cycle got %0d want 4", c);
        end
        checks++;
        e = exp_q.pop_front();
        if (err_len2 !== e[LW2-1:0]) begin
          errors++;
          $display("FAIL t2_err_len got %0d want %0d", err_len2, e);
        end
      end
      @(posedge clk);
      #1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL t2_timeout got no done want done in cycle 4");
    end
  endtask

  task automatic test_backpressure();
    run_word("backpressure", 3'b011, 3'b010, 3'd2, 4);
    @(negedge clk);
    checks++;
    if ({ready, done, synpe} !== 3'b100) begin
      errors++;
      $display("FAIL backpressure_ready_after got %b want 100", {ready, done, synpe});
    end
  endtask

  task automatic test_back_to_back();
    run_word("b2b_first", 3'b001, 3'b000, 3'd1, 0);
    run_word("b2b_second", 3'b111, 3'b110, 3'd3, 0);
  endtask

  task automatic test_reset_mid_run();
    logic [6:0] obs;
    logic saw_done;
    saw_done = 1'b0;
    @(negedge clk);
    start   = 1'b1;
    drnzero = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (msmpe !== 1'b1) begin
      errors++;
      $display("FAIL midrun_in_msm got %b want 1", msmpe);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    obs = {ready, synpe, snce, msmpe, bsel, ch_start, done};
    checks++;
    if (obs !== 7'b1000000) begin
      errors++;
      $display("FAIL midrun_outputs got %b want 1000000", obs);
    end
    checks++;
    if (err_len !== 3'd0) begin
      errors++;
      $display("FAIL midrun_err_len got %0d want 0", err_len);
    end
    for (int c = 0; c < 2 * T + 2; c++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL midrun_no_done got done=1 want none");
    end
    last_len = '0;
    run_word("after_reset", 3'b011, 3'b010, 3'd2, 0);
  endtask

  initial begin
    test_reset();
    test_no_errors();
    test_single_error();
    test_two_errors();
    test_overflow();
    test_overflow_t2();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
